// File: rtl/param_counter_pkg.sv
// Shared constants for the parameterised up/down counter and its prescaler.
package param_counter_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_PRESC_W = 4;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/param_counter_prescaler.sv
// Divides enabled cycles by presc+1, producing a single-cycle tick when the
// internal count reaches presc.
module param_counter_prescaler
    import param_counter_pkg::*;
#(
    parameter int PRESC_W = DEFAULT_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] r_cnt;
    logic               w_wrap;

    // The tick fires in the same cycle the count matches, so presc=0 ticks every enabled cycle.
    assign w_wrap = (r_cnt == presc);
    assign tick   = en && !clr && w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + ONE;
        end
    end

endmodule

// File: rtl/param_counter.sv
// Up/down counter with wrap or saturate at a runtime modulus, prescaled step,
// registered terminal-count pulse and sticky overflow flag.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int PRESC_W = DEFAULT_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               dir,
    input  logic               mode,
    input  logic [WIDTH-1:0]   modulus,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               ovf
);

    // No handshake: count/tc/ovf are registered and valid every cycle once reset releases.
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_tick;
    logic             w_presc_clr;
    logic [WIDTH-1:0] w_next;
    logic             w_bound;
    logic [WIDTH-1:0] w_load_val;

    // Load restarts the prescaler just like clear does.
    assign w_presc_clr = clr || load;

    param_counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (w_presc_clr),
        .presc (presc),
        .tick  (w_tick)
    );

    assign w_load_val = (load_val < modulus) ? load_val : modulus;

    always_comb begin
        w_next  = r_count;
        w_bound = 1'b0;
        if (dir == DIR_UP) begin
            if (r_count < modulus) begin
                w_next = r_count + ONE;
            end else begin
                w_next  = (mode == MODE_SAT) ? modulus : '0;
                w_bound = 1'b1;
            end
        end else begin
            if (r_count == '0) begin
                w_next  = (mode == MODE_SAT) ? '0 : modulus;
                w_bound = 1'b1;
            end else if (r_count > modulus) begin
                // Modulus was lowered below the count: pull back into range quietly.
                w_next = modulus;
            end else begin
                w_next = r_count - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load) begin
            r_count <= w_load_val;
            r_tc    <= 1'b0;
        end else if (w_tick) begin
            r_count <= w_next;
            r_tc    <= w_bound;
            if (w_bound) begin
                r_ovf <= 1'b1;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: a driver pushes model predictions per
// clock (and per async reset), a monitor pops and compares after each edge.
module tb_param_counter;
    import param_counter_pkg::*;

    localparam int W     = 8;
    localparam int PW    = 4;
    localparam int EXP_W = 16 + W + 2;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          en       = 1'b0;
    logic          clr      = 1'b0;
    logic          load     = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic          dir      = 1'b0;
    logic          mode     = 1'b0;
    logic [W-1:0]  modulus  = '0;
    logic [PW-1:0] presc    = '0;
    logic [W-1:0]  count;
    logic          tc;
    logic          ovf;

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;

    // Reference model state: what the outputs should be after the latest edge.
    int m_count = 0;
    int m_pre   = 0;
    int m_tc    = 0;
    int m_ovf   = 0;

    param_counter #(
        .WIDTH   (W),
        .PRESC_W (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .mode     (mode),
        .modulus  (modulus),
        .presc    (presc),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    task automatic model_step();
        int mod_i;
        int pr_i;
        int lv_i;
        bit tick;
        mod_i = int'(modulus);
        pr_i  = int'(presc);
        lv_i  = int'(load_val);
        if (clr) begin
            m_count = 0; m_pre = 0; m_tc = 0; m_ovf = 0;
        end else if (load) begin
            m_count = (lv_i < mod_i) ? lv_i : mod_i;
            m_pre   = 0;
            m_tc    = 0;
        end else if (!en) begin
            m_tc = 0;
        end else begin
            tick  = (m_pre == pr_i);
            m_pre = tick ? 0 : m_pre + 1;
            m_tc  = 0;
            if (tick) begin
                if (dir) begin
                    if (m_count < mod_i) m_count = m_count + 1;
                    else begin m_count = mode ? mod_i : 0; m_tc = 1; end
                end else if (m_count == 0) begin
                    m_count = mode ? 0 : mod_i;
                    m_tc    = 1;
                end else if (m_count > mod_i) begin
                    m_count = mod_i;
                end else begin
                    m_count = m_count - 1;
                end
                if (m_tc == 1) m_ovf = 1;
            end
        end
    endtask

    task automatic push_exp();
        exp_q.push_back({16'(phase), W'(m_count), 1'(m_tc), 1'(m_ovf)});
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        model_step();
        push_exp();
        @(negedge clk);
    endtask

    // Asserts rst between edges, holds it across one rising edge, releases on a falling edge.
    task automatic async_reset();
        #2;
        m_count = 0; m_pre = 0; m_tc = 0; m_ovf = 0;
        push_exp();
        push_exp();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({count, tc, ovf} !== e[W+1:0]) begin
                    n_fail++;
                    $display("FAIL outputs phase=%0d t=%0t: got count=%0d tc=%0b ovf=%0b, expected count=%0d tc=%0b ovf=%0b",
                             e[EXP_W-1:W+2], $time, count, tc, ovf, e[W+1:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        phase = 1;
        async_reset();

        // Wrap count 0..9 -> 0 with tc one cycle after the wrap edge.
        phase = 2;
        modulus = 8'd9; presc = '0; dir = DIR_UP; mode = MODE_WRAP; en = 1'b1;
        repeat (12) cycle();

        // Saturating count-down from a load of 2.
        phase = 3;
        modulus = 8'd5; dir = DIR_DOWN; mode = MODE_SAT; load_val = 8'd2; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (5) cycle();

        // Prescale by 4 with an en-low gap of 5 cycles.
        phase = 4;
        clr = 1'b1; presc = 4'd3; modulus = 8'd255; dir = DIR_UP; mode = MODE_WRAP;
        cycle();
        clr = 1'b0;
        repeat (9) cycle();
        en = 1'b0;
        repeat (5) cycle();
        en = 1'b1;
        repeat (8) cycle();

        // clr beats load beats tick; load clamps to modulus.
        phase = 5;
        presc = '0; load_val = 8'd50; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        clr = 1'b1; load = 1'b1;
        cycle();
        clr = 1'b0; load_val = 8'd200; modulus = 8'd100;
        cycle();
        load = 1'b0;
        repeat (2) cycle();

        // Modulus lowered below the count, counting up then down.
        phase = 6;
        modulus = 8'd255; load_val = 8'd7; load = 1'b1;
        cycle();
        load = 1'b0; modulus = 8'd3; dir = DIR_UP; mode = MODE_WRAP;
        cycle();
        modulus = 8'd255; load = 1'b1;
        cycle();
        load = 1'b0; modulus = 8'd3; dir = DIR_DOWN;
        repeat (2) cycle();

        // Async reset at count 42 with a load pending.
        phase = 7;
        modulus = 8'd255; load_val = 8'd42; load = 1'b1; dir = DIR_UP;
        cycle();
        load = 1'b0; en = 1'b0;
        cycle();
        load = 1'b1; load_val = 8'd99;
        async_reset();
        load = 1'b0; en = 1'b1;
        repeat (2) cycle();

        // modulus = 0: count pinned at 0, tc on every tick, both directions and modes.
        phase = 8;
        modulus = '0; presc = '0; dir = DIR_UP; mode = MODE_WRAP;
        repeat (3) cycle();
        dir = DIR_DOWN; mode = MODE_SAT;
        repeat (2) cycle();

        // Randomized traffic.
        phase = 9;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end
            en       = ($urandom_range(0, 9) != 0);
            clr      = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = W'($urandom_range(0, 255));
            dir      = ($urandom_range(0, 7) != 0) ? dir : ~dir;
            mode     = ($urandom_range(0, 15) != 0) ? mode : ~mode;
            if ($urandom_range(0, 24) == 0)
                modulus = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
            if (clr || load)
                presc = PW'($urandom_range(0, 3));
            cycle();
        end

        en = 1'b0; clr = 1'b0; load = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 SHALL have parameter PRESC_W, default 4, prescaler width in bits (legal 1..16).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port en  input  1  count enable, gates prescaler and counter.
REQ-006 SHALL have port clr  input  1  synchronous clear of count, prescaler, ovf.
REQ-007 SHALL have port load  input  1  synchronous parallel load request.
REQ-008 SHALL have port load_val  input  WIDTH  value applied on load.
REQ-009 SHALL have port dir  input  1  1 = count up, 0 = count down.
REQ-010 SHALL have port mode  input  1  0 = wrap (modulo), 1 = saturate.
REQ-011 SHALL have port modulus  input  WIDTH  terminal value; legal range of count is 0..modulus.
REQ-012 SHALL have port presc  input  PRESC_W  step occurs every presc+1 enabled cycles.
REQ-013 SHALL have port count  output  WIDTH  registered counter value.
REQ-014 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 SHALL have port ovf  output  1  sticky flag, set on any tc, cleared by clr or rst.

Function
REQ-016 SHALL apply per-cycle priority: rst > clr > load > step > hold.
REQ-017 clr SHALL set count=0, prescaler=0, ovf=0, tc=0 on the next edge.
REQ-018 load SHALL set count=min(load_val, modulus), prescaler=0, tc=0; ovf unchanged.
REQ-019 Prescaler SHALL increment each cycle en=1 and no clr/load; when prescaler==presc it SHALL return to 0 and generate an internal tick that cycle.
REQ-020 presc=0 SHALL produce a tick on every enabled cycle (no added latency).
REQ-021 en=0 SHALL freeze prescaler and count; tc SHALL be 0.
REQ-022 On tick, dir=1, count<modulus: count SHALL increment by 1, tc=0.
REQ-023 On tick, dir=1, count>=modulus: wrap mode SHALL set count=0; saturate mode SHALL set count=modulus; both SHALL assert tc for one cycle.
REQ-024 On tick, dir=0, count>0: count SHALL decrement by 1, tc=0; if count>modulus (modulus lowered at runtime) it SHALL instead set count=modulus, tc=0.
REQ-025 On tick, dir=0, count==0: wrap mode SHALL set count=modulus; saturate mode SHALL hold 0; both SHALL assert tc.
REQ-026 modulus=0 SHALL keep count at 0 and assert tc on every tick.
REQ-027 tc SHALL be registered, high in the cycle after the boundary tick edge, low otherwise; ovf SHALL set on the same edge as tc.
REQ-028 Arithmetic SHALL be unsigned WIDTH bits; no intermediate carry SHALL leak into count.
REQ-029 Changes to dir, mode, modulus, presc SHALL take effect on the next tick without resetting state.

Reset
REQ-030 rst=1 SHALL asynchronously force count=0, prescaler=0, tc=0, ovf=0.
REQ-031 Reset deassertion SHALL occur synchronously with clk; first step no earlier than presc+1 enabled cycles after release.
REQ-032 rst asserted mid-count SHALL discard any pending tick or load.

Structure
REQ-033 Shared package param_counter_pkg SHALL hold mode constants MODE_WRAP=0, MODE_SAT=1, direction constants DIR_DOWN=0, DIR_UP=1, and default parameter values.
REQ-034 Prescaler SHALL be a separate sub-module param_counter_prescaler (clk, rst, en, clr, presc, tick).
REQ-035 Block SHALL be instantiable inside tt_um_nishit0072e_counter with WIDTH=8, count on uo_out, tc/ovf on uio_out.

Verification
REQ-036 WIDTH=8, modulus=9, presc=0, dir=1, mode=0, en=1 from 0: count 0..9 then 0; tc high exactly one cycle after 9->0; ovf=1.
REQ-037 modulus=5, dir=0, mode=1, load_val=2: count 2,1,0,0,0; tc pulses each tick at 0; count never exceeds 5.
REQ-038 presc=3, modulus=255, dir=1: count increments every 4th enabled cycle; toggling en low 5 cycles shifts step by 5.
REQ-039 Same cycle clr=1, load=1, tick: count=0, ovf=0; next cycle load=1, load_val=200, modulus=100: count=100.
REQ-040 count=7, modulus lowered to 3, dir=1, mode=0: next tick count=0, tc=1; with dir=0 instead: count=3, tc=0.
REQ-041 rst pulsed asynchronously mid-cycle at count=42: count=0, tc=0, ovf=0 before next clk edge.
